dual_rail_tx_4bits: RTL and testbench

//  Clocked injector at the head of the asynchronous 4-bit dual-rail pipeline.

---
 rtl/dual_rail_tx_4bits.sv | 223 ++++++++++++++++++++++
 tb/tb_dual_rail_tx_4bits.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_rail_tx_4bits.sv
// dual_rail_tx_4bits: clocked injector feeding a 4-bit dual-rail async pipeline.
//
// Purpose
//   Binary nibbles arrive over a valid/ready port and queue in a small FIFO.
//   Each nibble leaves as one 4-phase return-to-zero token: codeword, wait for
//   ack, spacer, wait for ack release. Only then may the next codeword go out.
//
// Ports
//   clk        in   1  single clock, all state changes on posedge
//   rst        in   1  synchronous reset, active-high
//   in_valid   in   1  nibble offered
//   in_data    in   4  nibble to send
//   in_ready   out  1  FIFO not full (push on in_valid & in_ready)
//   data_out   out  8  dual-rail word, [2i+1]=true rail, [2i]=false rail of bit i
//   ack_in     in   1  asynchronous ack from the first pipeline stage
//   busy       out  1  FSM not idle or FIFO non-empty
//   tx_count   out  8  completed tokens, wraps 255->0
//   err        out  1  sticky handshake-timeout flag
//
// Parameters
//   DEPTH        FIFO entries, power of two, >= 2
//   SYNC_STAGES  flops in the ack_in synchronizer, >= 2
//   TIMEOUT_CYC  cycles a handshake phase may wait before err sets, 0 = off

module dual_rail_tx_4bits #(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic [7:0] data_out,
    input  logic       ack_in,
    output logic       busy,
    output logic [7:0] tx_count,
    output logic       err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYC);
    localparam bit            TMO_ON  = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RELEASE
    } state_t;

    // Each bit maps to {t,f}: 1 -> 10, 0 -> 01. Spacer (00) is all-zero.
    function automatic logic [7:0] encode(input logic [3:0] nib);
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            w[2*i+1] = nib[i];
            w[2*i]   = ~nib[i];
        end
        return w;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]             mem_q [DEPTH];
    logic [3:0]             mem_d [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_s;

    state_t                 state_q, state_d;
    logic [7:0]             data_q, data_d;
    logic [7:0]             tx_count_q, tx_count_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   err_q, err_d;

    logic                   push;
    logic                   pop;
    logic                   waiting;

    // ------------------------------------------------------------------
    // ack_in synchronizer; nothing downstream looks at ack_in directly
    // ------------------------------------------------------------------
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ack_in};
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // in_ready depends on the occupancy alone so the upstream handshake
    // has no combinational path back from in_valid.
    assign in_ready = (count_q != FULL);
    assign push     = in_valid && in_ready;

    // A stale ack still high in IDLE blocks the pop: the downstream stage
    // must have returned to zero before it can accept a new codeword.
    assign pop = (state_q == ST_IDLE) && (count_q != '0) && !ack_s;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Token FSM, timeout counter and output word
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        tx_count_d = tx_count_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        waiting    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    data_d  = encode(mem_q[rd_ptr_q]);
                    tmo_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ack_s) begin
                    data_d  = '0;
                    tmo_d   = '0;
                    state_d = ST_RELEASE;
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    tx_count_d = tx_count_q + 8'd1;
                    state_d    = ST_IDLE;
                end else begin
                    waiting = 1'b1;
                end
            end
            default: begin
                data_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Saturating wait counter; a timeout only flags, it never aborts
        // the token since the async side may still answer late.
        if (TMO_ON && waiting && (tmo_q != TMO_LIM)) begin
            tmo_d = tmo_q + TW'(1);
        end

        if (TMO_ON && waiting && (tmo_d == TMO_LIM)) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            data_q     <= '0;
            tx_count_q <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sync_q     <= sync_d;
            state_q    <= state_d;
            data_q     <= data_d;
            tx_count_q <= tx_count_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // data_out comes straight from flops so every rail switches together.
    assign data_out = data_q;
    assign busy     = (state_q != ST_IDLE) || (count_q != '0);
    assign tx_count = tx_count_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dual_rail_tx_4bits.sv
// tb_dual_rail_tx_4bits: directed and table-driven bench for dual_rail_tx_4bits.
// A behavioural downstream stage decodes tokens and acknowledges them.

module tb_dual_rail_tx_4bits;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [7:0] data_out;
    logic       ack_in;
    logic       busy;
    logic [7:0] tx_count;
    logic       err;

    logic       man_ack;
    logic       resp_ack;
    logic       resp_en;
    int         resp_dly_max;

    int checks;
    int failures;

    int         ph;
    int         bad_pairs;
    int         bad_seq;
    logic [7:0] rxw_q[$];

    typedef struct {
        logic [3:0] nib;
        logic [7:0] exp_word;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    assign ack_in = resp_en ? resp_ack : man_ack;

    dual_rail_tx_4bits #(
        .DEPTH(2),
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .data_out(data_out),
        .ack_in(ack_in),
        .busy(busy),
        .tx_count(tx_count),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while (!(busy == 1'b0 && ph == 0 && ack_in == 1'b0) && n < max) begin
            tick();
            n++;
        end
        chk(name, 32'(n < max), 32'd1);
    endtask

    function automatic logic [3:0] decode(input logic [7:0] w);
        logic [3:0] n;
        for (int i = 0; i < 4; i++) begin
            n[i] = w[2*i+1];
        end
        return n;
    endfunction

    // Downstream model: 4-phase responder with random delays, also
    // watching for illegal rail pairs and out-of-order word changes.
    initial begin
        logic [7:0] word;
        int         cnt;
        resp_ack  = 1'b0;
        ph        = 0;
        cnt       = 0;
        word      = '0;
        bad_pairs = 0;
        bad_seq   = 0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 4; i++) begin
                if (data_out[2*i+1] && data_out[2*i]) bad_pairs++;
            end
            if (!resp_en) begin
                ph       = 0;
                resp_ack = 1'b0;
                cnt      = 0;
            end else begin
                case (ph)
                    0: begin
                        if (data_out != 8'h00) begin
                            for (int i = 0; i < 4; i++) begin
                                if (!(data_out[2*i+1] ^ data_out[2*i])) bad_seq++;
                            end
                            word = data_out;
                            rxw_q.push_back(data_out);
                            cnt = int'($urandom_range(0, resp_dly_max));
                            ph  = 1;
                        end
                    end
                    1: begin
                        if (data_out != word) bad_seq++;
                        if (cnt == 0) begin
                            resp_ack = 1'b1;
                            ph       = 2;
                        end else begin
                            cnt--;
                        end
                    end
                    2: begin
                        if (data_out == 8'h00) begin
                            cnt = int'($urandom_range(0, resp_dly_max));
                            ph  = 3;
                        end else if (data_out != word) begin
                            bad_seq++;
                        end
                    end
                    default: begin
                        if (data_out != 8'h00) bad_seq++;
                        if (cnt == 0) begin
                            resp_ack = 1'b0;
                            ph       = 0;
                        end else begin
                            cnt--;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        int         base;
        int         n;
        int         tmo_acc;
        int         mism;
        logic       acc;
        logic [3:0] nib;
        logic [3:0] sent[$];

        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 4'h0;
        man_ack      = 1'b0;
        resp_en      = 1'b0;
        resp_dly_max = 0;

        vecs[0] = '{4'h0, 8'h55, 8'd5};
        vecs[1] = '{4'h1, 8'h56, 8'd6};
        vecs[2] = '{4'h3, 8'h5A, 8'd7};
        vecs[3] = '{4'h5, 8'h66, 8'd8};
        vecs[4] = '{4'h7, 8'h6A, 8'd9};
        vecs[5] = '{4'hA, 8'h99, 8'd10};
        vecs[6] = '{4'hC, 8'hA5, 8'd11};
        vecs[7] = '{4'hF, 8'hAA, 8'd12};

        // Reset state
        tick(); tick(); tick();
        rst = 1'b0;
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_count", 32'(tx_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // 1: single token 4'hA, ack after 3 cycles
        in_valid = 1'b1; in_data = 4'hA;
        tick();
        in_valid = 1'b0;
        chk("t1_spacer_at_push", 32'(data_out), 32'h00);
        chk("t1_busy_after_push", 32'(busy), 32'd1);
        tick();
        chk("t1_latency_word", 32'(data_out), 32'h99);
        tick(); tick(); tick();
        man_ack = 1'b1;
        tick(); tick();
        chk("t1_hold_until_ack_s", 32'(data_out), 32'h99);
        tick();
        chk("t1_spacer_after_ack", 32'(data_out), 32'h00);
        tick(); tick(); tick();
        chk("t1_count_before_release", 32'(tx_count), 32'd0);
        man_ack = 1'b0;
        tick(); tick();
        chk("t1_count_sync_delay", 32'(tx_count), 32'd0);
        tick();
        chk("t1_tx_count", 32'(tx_count), 32'd1);
        chk("t1_busy_done", 32'(busy), 32'd0);

        // 2+6: back-to-back pushes with no ack, push during IDLE pop
        in_valid = 1'b1; in_data = 4'h0;
        tick();
        chk("t2_ready_cnt1", 32'(in_ready), 32'd1);
        in_data = 4'hF;
        tick();
        chk("t6_word_popped", 32'(data_out), 32'h55);
        chk("t6_ready_cnt_stays1", 32'(in_ready), 32'd1);
        in_data = 4'h5;
        tick();
        chk("t2_ready_full", 32'(in_ready), 32'd0);
        in_data = 4'h9;
        tick(); tick();
        chk("t2_ready_still_full", 32'(in_ready), 32'd0);
        chk("t2_word_held", 32'(data_out), 32'h55);
        in_valid = 1'b0;
        base = rxw_q.size();
        resp_dly_max = 2;
        resp_en = 1'b1;
        wait_idle("t2_drain_timeout", 300);
        chk("t2_drain_tokens", 32'(rxw_q.size() - base), 32'd3);
        if (rxw_q.size() >= base + 3) begin
            chk("t2_order0", 32'(rxw_q[base]), 32'h55);
            chk("t2_order1", 32'(rxw_q[base+1]), 32'hAA);
            chk("t2_order2", 32'(rxw_q[base+2]), 32'h66);
        end
        chk("t2_tx_count", 32'(tx_count), 32'd4);

        // Encoding table
        resp_dly_max = 1;
        for (int i = 0; i < 8; i++) begin
            chk("tbl_ready", 32'(in_ready), 32'd1);
            base = rxw_q.size();
            in_valid = 1'b1; in_data = vecs[i].nib;
            tick();
            in_valid = 1'b0;
            wait_idle("tbl_timeout", 100);
            chk("tbl_tokens", 32'(rxw_q.size() - base), 32'd1);
            if (rxw_q.size() > base) begin
                chk("tbl_word", 32'(rxw_q[base]), 32'(vecs[i].exp_word));
            end
            chk("tbl_tx_count", 32'(tx_count), 32'(vecs[i].exp_cnt));
        end
        resp_en = 1'b0;

        // 3: ack stuck high -> timeout in RELEASE
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 4'h3;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t3_word", 32'(data_out), 32'h5A);
        man_ack = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (data_out != 8'h00 && n < 10);
        chk("t3_cycles_to_spacer", 32'(n), 32'd3);
        repeat (254) tick();
        chk("t3_err_not_yet", 32'(err), 32'd0);
        tick();
        chk("t3_err_set", 32'(err), 32'd1);
        chk("t3_spacer_held", 32'(data_out), 32'h00);
        chk("t3_tx_count", 32'(tx_count), 32'd0);
        man_ack = 1'b0;
        repeat (5) tick();
        chk("t3_late_release_count", 32'(tx_count), 32'd1);
        chk("t3_err_sticky", 32'(err), 32'd1);

        // 4: reset while a codeword is driven with FIFO entries pending
        in_valid = 1'b1; in_data = 4'h7;
        tick();
        in_data = 4'h1;
        tick();
        in_data = 4'h2;
        tick();
        in_valid = 1'b0;
        chk("t4_word", 32'(data_out), 32'h6A);
        rst = 1'b1;
        tick();
        chk("t4_rst_data_out", 32'(data_out), 32'h00);
        chk("t4_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t4_rst_tx_count", 32'(tx_count), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        chk("t4_no_leftover", 32'(data_out), 32'h00);
        chk("t4_still_idle", 32'(busy), 32'd0);

        // 5: stream of 300 random nibbles, random ack delays
        base = rxw_q.size();
        bad_pairs = 0;
        bad_seq = 0;
        resp_dly_max = 4;
        resp_en = 1'b1;
        tmo_acc = 0;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            nib = 4'($urandom_range(0, 15));
            in_data = nib;
            in_valid = 1'b1;
            acc = 1'b0;
            n = 0;
            while (!acc && n < 200) begin
                acc = in_ready;
                tick();
                n++;
            end
            in_valid = 1'b0;
            if (!acc) tmo_acc++;
            sent.push_back(nib);
        end
        chk("t5_accept_timeouts", 32'(tmo_acc), 32'd0);
        wait_idle("t5_drain_timeout", 5000);
        chk("t5_tokens", 32'(rxw_q.size() - base), 32'd300);
        mism = 0;
        for (int i = 0; i < 300; i++) begin
            if (base + i < rxw_q.size()) begin
                if (decode(rxw_q[base+i]) != sent[i]) mism++;
            end
        end
        chk("t5_order_mismatches", 32'(mism), 32'd0);
        chk("t5_tx_count", 32'(tx_count), 32'd44);
        chk("t5_pairs_11", 32'(bad_pairs), 32'd0);
        chk("t5_protocol", 32'(bad_seq), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        resp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
